// File: rtl/tl_pkg.sv
// Shared types for the intersection controller: FSM states and lamp encodings.
package tl_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    RED_A     = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    RED_B     = 3'd5,
    PED_WALK  = 3'd6
  } state_e;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;

  typedef struct packed {
    lamp_t ns;
    lamp_t ew;
    logic  walk;
  } lamps_t;

  localparam lamp_t LAMP_RED    = lamp_t'(3'b100);
  localparam lamp_t LAMP_YELLOW = lamp_t'(3'b010);
  localparam lamp_t LAMP_GREEN  = lamp_t'(3'b001);

  // Lamp set shown while the FSM sits in state s.
  function automatic lamps_t decode_lamps(input state_e s);
    lamps_t l;
    l.ns   = LAMP_RED;
    l.ew   = LAMP_RED;
    l.walk = 1'b0;
    case (s)
      NS_GREEN:  l.ns   = LAMP_GREEN;
      NS_YELLOW: l.ns   = LAMP_YELLOW;
      EW_GREEN:  l.ew   = LAMP_GREEN;
      EW_YELLOW: l.ew   = LAMP_YELLOW;
      PED_WALK:  l.walk = 1'b1;
      default:   ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times each phase; zero_c marks the last cycle.
module phase_timer #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic [CNT_W-1:0] count,
  output logic             zero_c
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = load ? value : count_q - CNT_W'(1);
  end

  // Reset is applied by the owner forcing a load.
  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count  = count_q;
  assign zero_c = (count_q == '0);

endmodule

// File: rtl/intersection_controller.sv
// Two-road traffic light sequencer with all-red clearance and latched pedestrian walk.
module intersection_controller
  import tl_pkg::*;
#(
  parameter int unsigned CNT_W    = 5,
  parameter int unsigned GREEN_T  = 20,
  parameter int unsigned YELLOW_T = 4,
  parameter int unsigned RED_T    = 2,
  parameter int unsigned WALK_T   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ped_req,
  output logic             ns_red,
  output logic             ns_yellow,
  output logic             ns_green,
  output logic             ew_red,
  output logic             ew_yellow,
  output logic             ew_green,
  output logic             walk,
  output logic             ped_ack,
  output logic [CNT_W-1:0] count
);

  state_e           state_q, state_d;
  logic             nxt_ew_q, nxt_ew_d;
  logic             ped_pend_q, ped_pend_d;
  lamps_t           lamps_q, lamps_d;
  logic             illegal_c;
  logic             tmr_load_c;
  logic [CNT_W-1:0] tmr_value_c;
  logic             tmr_zero_c;

  // Countdown load value for a phase: duration minus one.
  function automatic logic [CNT_W-1:0] dur_of(input state_e s);
    case (s)
      NS_GREEN, EW_GREEN:   return CNT_W'(GREEN_T - 1);
      NS_YELLOW, EW_YELLOW: return CNT_W'(YELLOW_T - 1);
      PED_WALK:             return CNT_W'(WALK_T - 1);
      default:              return CNT_W'(RED_T - 1);
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    nxt_ew_d  = nxt_ew_q;
    illegal_c = 1'b0;
    case (state_q)
      NS_GREEN:  if (tmr_zero_c) state_d = NS_YELLOW;
      NS_YELLOW: if (tmr_zero_c) state_d = RED_A;
      EW_GREEN:  if (tmr_zero_c) state_d = EW_YELLOW;
      EW_YELLOW: if (tmr_zero_c) state_d = RED_B;
      RED_A: if (tmr_zero_c) begin
        if (ped_pend_q) begin
          state_d  = PED_WALK;
          nxt_ew_d = 1'b1;
        end else begin
          state_d = EW_GREEN;
        end
      end
      RED_B: if (tmr_zero_c) begin
        if (ped_pend_q) begin
          state_d  = PED_WALK;
          nxt_ew_d = 1'b0;
        end else begin
          state_d = NS_GREEN;
        end
      end
      PED_WALK:  if (tmr_zero_c) state_d = nxt_ew_q ? EW_GREEN : NS_GREEN;
      default: begin
        state_d   = RED_B;
        illegal_c = 1'b1;
      end
    endcase

    // Entering the walk clears the request; requests during the walk are dropped.
    if (state_d == PED_WALK) begin
      ped_pend_d = 1'b0;
    end else if (ped_req && (state_q != PED_WALK)) begin
      ped_pend_d = 1'b1;
    end else begin
      ped_pend_d = ped_pend_q;
    end

    lamps_d     = decode_lamps(state_d);
    tmr_load_c  = !rst_n || tmr_zero_c || illegal_c;
    tmr_value_c = !rst_n ? CNT_W'(RED_T - 1) : dur_of(state_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RED_B;
      nxt_ew_q   <= 1'b0;
      ped_pend_q <= 1'b0;
      lamps_q    <= decode_lamps(RED_B);
    end else begin
      state_q    <= state_d;
      nxt_ew_q   <= nxt_ew_d;
      ped_pend_q <= ped_pend_d;
      lamps_q    <= lamps_d;
    end
  end

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .load   (tmr_load_c),
    .value  (tmr_value_c),
    .count  (count),
    .zero_c (tmr_zero_c)
  );

  assign ns_red    = lamps_q.ns.red;
  assign ns_yellow = lamps_q.ns.yellow;
  assign ns_green  = lamps_q.ns.green;
  assign ew_red    = lamps_q.ew.red;
  assign ew_yellow = lamps_q.ew.yellow;
  assign ew_green  = lamps_q.ew.green;
  assign walk      = lamps_q.walk;
  assign ped_ack   = ped_pend_q;

  // Safety properties on the lamp outputs actually driven to the field.
  a_no_conflict: assert property (@(posedge clk) disable iff (!rst_n)
    !((ns_green || ns_yellow) && (ew_green || ew_yellow)));
  a_walk_red: assert property (@(posedge clk) disable iff (!rst_n)
    walk |-> (ns_red && ew_red));
  a_green_after_red: assert property (@(posedge clk) disable iff (!rst_n)
    ($rose(ns_green) || $rose(ew_green)) |-> $past(ns_red && ew_red));

endmodule

// File: tb/tb_intersection_controller.sv
// Random-stimulus bench comparing three controller configurations against a phase-table model.
module tb_intersection_controller;

  localparam int unsigned CW = 5;
  localparam int P_NSG = 0, P_NSY = 1, P_RA = 2, P_EWG = 3, P_EWY = 4, P_RB = 5, P_WK = 6;

  logic clk = 1'b0;
  logic rst_n;
  logic ped_req;
  logic ped_fast = 1'b1;
  logic ped_long = 1'b0;

  // {ns r,y,g, ew r,y,g, walk, ped_ack, count}
  logic [12:0] obs0, obs1, obs2;
  logic [12:0] obs [3];

  int n_cmp = 0;
  int n_bad = 0;

  int dur [3][7];
  int ph [3];
  int rem [3];
  bit pend [3];
  bit aft [3];
  bit mvalid = 1'b0;

  always #5 clk = ~clk;

  intersection_controller u_dut (
    .clk(clk), .rst_n(rst_n), .ped_req(ped_req),
    .ns_red(obs0[12]), .ns_yellow(obs0[11]), .ns_green(obs0[10]),
    .ew_red(obs0[9]), .ew_yellow(obs0[8]), .ew_green(obs0[7]),
    .walk(obs0[6]), .ped_ack(obs0[5]), .count(obs0[4:0])
  );

  intersection_controller #(.GREEN_T(1), .YELLOW_T(1), .RED_T(1), .WALK_T(1)) u_fast (
    .clk(clk), .rst_n(rst_n), .ped_req(ped_fast),
    .ns_red(obs1[12]), .ns_yellow(obs1[11]), .ns_green(obs1[10]),
    .ew_red(obs1[9]), .ew_yellow(obs1[8]), .ew_green(obs1[7]),
    .walk(obs1[6]), .ped_ack(obs1[5]), .count(obs1[4:0])
  );

  intersection_controller #(.GREEN_T(32)) u_long (
    .clk(clk), .rst_n(rst_n), .ped_req(ped_long),
    .ns_red(obs2[12]), .ns_yellow(obs2[11]), .ns_green(obs2[10]),
    .ew_red(obs2[9]), .ew_yellow(obs2[8]), .ew_green(obs2[7]),
    .walk(obs2[6]), .ped_ack(obs2[5]), .count(obs2[4:0])
  );

  assign obs[0] = obs0;
  assign obs[1] = obs1;
  assign obs[2] = obs2;

  // One clock of the intersection rules for configuration i.
  task automatic model_step(input int i, input bit rst, input bit req);
    bit was_walk;
    bit entered_walk;
    int nx;
    if (!rst) begin
      ph[i] = P_RB; rem[i] = dur[i][P_RB]; pend[i] = 1'b0; aft[i] = 1'b0;
      return;
    end
    was_walk = (ph[i] == P_WK);
    entered_walk = 1'b0;
    if (rem[i] > 1) begin
      rem[i] = rem[i] - 1;
    end else begin
      nx = P_RB;
      case (ph[i])
        P_NSG: nx = P_NSY;
        P_NSY: nx = P_RA;
        P_EWG: nx = P_EWY;
        P_EWY: nx = P_RB;
        P_RA:  if (pend[i]) begin nx = P_WK; aft[i] = 1'b1; end else nx = P_EWG;
        P_RB:  if (pend[i]) begin nx = P_WK; aft[i] = 1'b0; end else nx = P_NSG;
        default: nx = aft[i] ? P_EWG : P_NSG;
      endcase
      entered_walk = (nx == P_WK);
      ph[i] = nx;
      rem[i] = dur[i][nx];
    end
    if (entered_walk) pend[i] = 1'b0;
    else if (req && !was_walk) pend[i] = 1'b1;
  endtask

  function automatic logic [12:0] model_out(input int i);
    logic [2:0] ns = 3'b100;
    logic [2:0] ew = 3'b100;
    if (ph[i] == P_NSG) ns = 3'b001;
    if (ph[i] == P_NSY) ns = 3'b010;
    if (ph[i] == P_EWG) ew = 3'b001;
    if (ph[i] == P_EWY) ew = 3'b010;
    return {ns, ew, ph[i] == P_WK, pend[i], CW'(rem[i] - 1)};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) mvalid = 1'b1;
    if (mvalid) begin
      model_step(0, rst_n, ped_req);
      model_step(1, rst_n, ped_fast);
      model_step(2, rst_n, ped_long);
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obs[i] !== model_out(i)) begin
          n_bad++;
          $display("FAIL cycle_check dut%0d t=%0t got %b expected %b", i, $time, obs[i], model_out(i));
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Pins both the DUT and the model to a hand-computed output vector.
  task automatic pin(input string nm, input int i, input logic [12:0] exp);
    logic [12:0] mo;
    mo = model_out(i);
    n_cmp += 2;
    if (obs[i] !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %b expected %b", nm, i, obs[i], exp);
    end
    if (mo !== exp) begin
      n_bad++;
      $display("FAIL %s model%0d: got %b expected %b", nm, i, mo, exp);
    end
  endtask

  initial begin
    int walks;
    bit prev_walk;
    bit found;
    dur[0] = '{20, 4, 2, 20, 4, 2, 10};
    dur[1] = '{1, 1, 1, 1, 1, 1, 1};
    dur[2] = '{32, 4, 2, 32, 4, 2, 10};
    rst_n = 1'b0;
    ped_req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Deterministic opening: nominal cycle, then one pedestrian pulse during NS green.
    for (int p = 0; p <= 90; p++) begin
      @(negedge clk);
      case (p)
        0:  begin
              pin("redb_after_reset", 0, 13'b100_100_0_0_00000);
              pin("fast_nsg", 1, 13'b001_100_0_1_00000);
            end
        1:  begin
              pin("nsg_entry", 0, 13'b001_100_0_0_10011);
              pin("long_nsg_entry", 2, 13'b001_100_0_0_11111);
            end
        3:  pin("fast_walk_a", 1, 13'b100_100_1_0_00000);
        4:  pin("fast_ewg_ack_clear", 1, 13'b100_001_0_0_00000);
        7:  pin("fast_walk_b", 1, 13'b100_100_1_0_00000);
        21: pin("nsy_entry", 0, 13'b010_100_0_0_00011);
        25: pin("reda_entry", 0, 13'b100_100_0_0_00001);
        27: pin("ewg_entry", 0, 13'b100_001_0_0_10011);
        32: pin("long_nsg_last", 2, 13'b001_100_0_0_00000);
        33: pin("long_nsy_entry", 2, 13'b010_100_0_0_00011);
        53: pin("period_nsg", 0, 13'b001_100_0_0_10011);
        61: pin("ped_latched", 0, 13'b001_100_0_1_01011);
        78: pin("reda_ack_held", 0, 13'b100_100_0_1_00000);
        79: pin("walk_entry", 0, 13'b100_100_1_0_01001);
        89: pin("ewg_after_walk", 0, 13'b100_001_0_0_10011);
        default: ;
      endcase
      ped_req = (p == 60);
    end

    // Random pedestrian traffic with occasional mid-phase resets.
    for (int k = 0; k < 2500; k++) begin
      @(negedge clk);
      ped_req = ($urandom_range(0, 15) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
    end

    // Button held down: a walk after every all-red phase.
    rst_n = 1'b1;
    ped_req = 1'b1;
    walks = 0;
    prev_walk = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (obs0[6] && !prev_walk) walks++;
      prev_walk = obs0[6];
    end
    check("held_walk_count_ge7", 32'(walks >= 7), 1);

    // Reset pulse in the middle of EW green.
    ped_req = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (ph[0] == P_EWG && rem[0] == 8) found = 1'b1;
    end
    check("find_ewg_count7", 32'(found), 1);
    if (found) begin
      check("ewg_count_before_reset", 32'(obs0[4:0]), 7);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      pin("midphase_reset", 0, 13'b100_100_0_0_00001);
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
